// File: rtl/serial_frame_pkg.sv
// Shared definitions for the start/data/stop serial link (transmitter and receiver).
package serial_frame_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Line levels
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Mod-CLKS_PER_BIT counter that flags the last clock of each serial bit.
// Holds its count while disabled; clr restarts the bit period from zero.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Bit-end tick: last clock of the current bit period (every clock when CLKS_PER_BIT=1)
    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, wrap on tick, otherwise advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (tick)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CW'(1);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, DATA_W data bits LSB-first,
// stop bit, each held CLKS_PER_BIT clocks. All outputs come straight from flops,
// so each output register is loaded with the value belonging to the next state.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              tx_done
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              sout_q, sout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rdy_q, rdy_d;
    logic              xfer;
    logic              tick;
    logic              tick_en;

    // ready is only ever high in IDLE, so this is the handshake
    assign xfer    = din_valid && rdy_q;
    assign tick_en = (state_q != IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (xfer),
        .en     (tick_en),
        .tick   (tick)
    );

    // Next-state, shifter and next output values
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sout_d = IDLE_LEVEL;
                if (xfer) begin
                    state_d = START;
                    shreg_d = din;
                    sout_d  = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    sout_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        sout_d  = STOP_BIT;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IW'(1);
                        // next bit is the new LSB after the shift
                        sout_d  = shreg_d[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    sout_d  = IDLE_LEVEL;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    // State, datapath and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign sout      = sout_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;
    assign din_ready = rdy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an 8-bit/4-clock instance and a 1-bit/1-clock instance.
// Words are queued when handed over and the line is checked clock by clock against them.
module tb_serial_frame_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready, sout, busy, tx_done;
    logic          din1, dv1;
    logic          rdy1, sout1, busy1, done1;

    int            n_chk;
    int            n_fail;
    int            cyc;
    int            frame_start;
    logic [DW-1:0] sbq[$];
    logic          sbq1[$];

    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .sout     (sout),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (din1),
        .din_valid(dv1),
        .din_ready(rdy1),
        .sout     (sout1),
        .busy     (busy1),
        .tx_done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k == DW + 1) return 1'b1;
        return w[k-1];
    endfunction

    // Called at the negedge just before the transfer edge. keep=1 leaves din_valid
    // high with din=nxt for the whole frame, so nxt is transferred on the tx_done cycle.
    task automatic frame_a(input logic keep, input logic [DW-1:0] nxt);
        logic [DW-1:0] w;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        w = sbq.pop_front();
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == 0) begin
                frame_start = cyc;
                if (keep) din = nxt;
                else      din_valid = 1'b0;
            end
            chk("sout", sout, exp_bit(w, c / CPB));
            chk("busy", busy, 1);
            chk("ready_busy", din_ready, 0);
            chk("done_early", tx_done, 0);
        end
        @(negedge clk);
        chk("tx_done", tx_done, 1);
        chk("busy_end", busy, 0);
        chk("ready_end", din_ready, 1);
        chk("sout_end", sout, 1);
        if (keep) sbq.push_back(nxt);
    endtask

    task automatic frame_1(input logic keep, input logic nxt);
        logic w;
        logic e;
        if (sbq1.size() == 0) begin
            chk("sb1_empty", 1, 0);
            return;
        end
        w = sbq1.pop_front();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (keep) din1 = nxt;
                else      dv1 = 1'b0;
            end
            e = (c == 0) ? 1'b0 : (c == 1) ? w : 1'b1;
            chk("sout1", sout1, e);
            chk("busy1", busy1, 1);
            chk("ready1_busy", rdy1, 0);
            chk("done1_early", done1, 0);
        end
        @(negedge clk);
        chk("tx_done1", done1, 1);
        chk("ready1_end", rdy1, 1);
        chk("busy1_end", busy1, 0);
        chk("sout1_end", sout1, 1);
        if (keep) sbq1.push_back(nxt);
    endtask

    task automatic idle_a();
        @(negedge clk);
        chk("idle_sout", sout, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", tx_done, 0);
        chk("idle_ready", din_ready, 1);
    endtask

    initial begin
        int s0;
        logic [DW-1:0] w;
        n_chk = 0;
        n_fail = 0;
        frame_start = 0;
        reset_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        din1 = 1'b0;
        dv1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sout", sout, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", din_ready, 1);
        chk("rst_sout1", sout1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_ready1", rdy1, 1);
        reset_n = 1'b1;
        idle_a();

        // A5 frame, then 3C offered throughout busy: only taken after tx_done
        din = 8'hA5;
        din_valid = 1'b1;
        sbq.push_back(8'hA5);
        frame_a(1'b1, 8'h3C);
        frame_a(1'b0, '0);
        idle_a();

        // Back-to-back 00 then FF with valid held
        din = 8'h00;
        din_valid = 1'b1;
        sbq.push_back(8'h00);
        frame_a(1'b1, 8'hFF);
        s0 = frame_start;
        frame_a(1'b0, '0);
        chk("b2b_period", frame_start - s0, FRAME + 1);
        idle_a();

        // Reset during data bit 3 of A5
        din = 8'hA5;
        din_valid = 1'b1;
        sbq.push_back(8'hA5);
        w = sbq.pop_front();
        for (int c = 0; c < 3 * CPB + CPB + 2; c++) begin
            @(negedge clk);
            if (c == 0) din_valid = 1'b0;
            chk("abort_sout", sout, exp_bit(w, c / CPB));
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_sout_rst", sout, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", tx_done, 0);
        chk("abort_ready", din_ready, 1);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", tx_done, 0);
            chk("abort_idle", sout, 1);
        end
        din = 8'h5A;
        din_valid = 1'b1;
        sbq.push_back(8'h5A);
        frame_a(1'b0, '0);
        idle_a();

        // DATA_W=1, CLKS_PER_BIT=1: 1 then 0 back-to-back on the tx_done cycle
        din1 = 1'b1;
        dv1 = 1'b1;
        sbq1.push_back(1'b1);
        frame_1(1'b1, 1'b0);
        frame_1(1'b0, 1'b0);
        @(negedge clk);
        chk("idle1_sout", sout1, 1);
        chk("idle1_done", done1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
